friscv_alu_mc: RTL and testbench
================================

Name: friscv_alu_mc

Overview:
Parametrised, multi-cycle successor to the combinational ALU operation set.
- Executes the nine base ops (AND, OR, XOR, ADD, SUB, SLT, SLL, SAR, SLR) in a single registered cycle.
- Adds iterative MUL (low half), DIVU and REMU ops that take WIDTH cycles each.
- Sits in the execute stage between the decode/operand-read logic and writeback.
- Uses valid/ready handshakes on the input and output sides so the pipeline can stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two and at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort: drops any in-flight op.
- op_valid  in  1  operation request valid.
- op_ready  out  1  block can accept a request.
- op_code  in  4  operation select, values from the alu_op_t package enum.
- op_a  in  WIDTH  operand A (dividend / multiplicand).
- op_b  in  WIDTH  operand B (divisor / multiplier / shift amount).
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  result.
- res_zero  out  1  res_data == 0.
- res_dbz  out  1  DIVU/REMU was issued with op_b == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - res_valid = 0, res_data = 0, res_zero = 1, res_dbz = 0.
  - All internal accumulators are cleared.
  - op_ready = 1 once reset is released.
- States:
  - IDLE: op_ready = 1. On op_valid, the operands and op_code are captured.
    - Base op: computed this cycle; state goes to DONE at the next edge.
    - MUL/DIVU/REMU: state goes to BUSY with the iteration counter = 0.
  - BUSY: op_ready = 0. One iteration per cycle.
    - After iteration WIDTH-1 the result is registered and the state goes to DONE.
  - DONE: res_valid = 1 and op_ready = 0. res_data is held stable while res_ready is low.
    - On res_ready the state returns to IDLE.
    - res_valid drops at that edge. No back-to-back issue from DONE.
- Latency, measured from the accepting edge to the first res_valid cycle:
  - Base ops: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles.
- Arithmetic (all results truncated to WIDTH):
  - ADD and SUB wrap modulo 2^WIDTH.
  - SLT compares signed: result 1 if A < B, else 0.
  - SLL, SLR and SAR use op_b[SHW-1:0] only. SAR replicates the sign bit.
  - MUL uses the shift-add algorithm and returns the low WIDTH bits of the unsigned product.
  - DIVU/REMU use restoring shift-subtract on unsigned operands.
- Divide by zero (op_b == 0):
  - DIVU returns all ones; REMU returns op_a. Both set res_dbz.
  - The op still takes the full WIDTH+1 latency, for deterministic timing.
- res_dbz is 0 for every other op. res_zero is computed from the registered res_data.
- Unused op_code values (>= 12) complete as a base op with res_data = 0.
- flush has priority over everything except reset.
  - In any state it returns the block to IDLE at the next edge and clears res_valid.
  - A request presented with flush high is not accepted.
- Simultaneous res_ready and a new op_valid in DONE: only the result handshake completes; the new op is accepted from IDLE on the following cycle.
- Operand changes after acceptance have no effect, because the operands are captured.
- Reset asserted mid-BUSY aborts the op immediately; no partial result is visible.

Decomposition:
- friscv_pkg holds:
  - typedef enum logic [3:0] alu_op_t, with the existing codes 0x0-0x8 unchanged plus MUL=0x9, DIVU=0xA, REMU=0xB;
  - typedef enum logic [1:0] alu_state_t {IDLE, BUSY, DONE}.
- Sub-module friscv_muldiv_iter (same clk/rst_n) holds the shared accumulator, the counter and the shift-add / shift-subtract datapath.
  - Interface: start, op select and operands in; done pulse and result out.
  - Its counter width is $clog2(WIDTH)+1.
- The base ops remain a combinational always block in the top.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 0x00000001 (WIDTH=32) -> res_valid 1 cycle after accept, res_data 0x80000000, res_zero 0.
- SAR 0x80000000 by op_b 0x24 (only the low 5 bits are used, so shift 4) -> 0xF8000000. SLT 0xFFFFFFFF vs 0x00000001 -> 1.
- MUL 0xFFFFFFFF * 3 -> 0xFFFFFFFD with res_valid exactly 33 cycles after accept; op_ready low throughout.
- DIVU 100/7 -> 14, then REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF with res_dbz 1; REMU 5/0 -> 5 with res_dbz 1.
- Backpressure: hold res_ready low for 10 cycles after a SUB 3-3 -> res_data 0 and res_zero 1 stay stable, no new op accepted; release -> IDLE on the next cycle.
- Flush at cycle 10 of a DIVU -> IDLE next edge, no res_valid. Assert rst_n low mid-MUL -> outputs go to reset values asynchronously. Next op ADD 1+1 -> 2.

Source files
------------

// File: rtl/friscv_pkg.sv
// -----------------------------------------------------------------------------
// friscv_pkg
// Shared types for the multi-cycle execute-stage ALU.
//   alu_op_t    : 4-bit operation select. Codes 0x0-0x8 are the base ops and
//                 keep their original encoding; 0x9-0xB are the iterative ops.
//   alu_state_t : control state of friscv_alu_mc.
//   is_iter_op  : op_code needs the multi-cycle datapath.
//   is_div_op   : op_code is DIVU or REMU (divide-by-zero flag applies).
// -----------------------------------------------------------------------------
package friscv_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'h0,
        ALU_OR   = 4'h1,
        ALU_XOR  = 4'h2,
        ALU_ADD  = 4'h3,
        ALU_SUB  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SAR  = 4'h7,
        ALU_SLR  = 4'h8,
        ALU_MUL  = 4'h9,
        ALU_DIVU = 4'hA,
        ALU_REMU = 4'hB
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_t;

    function automatic logic is_iter_op(input logic [3:0] code);
        return code inside {ALU_MUL, ALU_DIVU, ALU_REMU};
    endfunction

    function automatic logic is_div_op(input logic [3:0] code);
        return code inside {ALU_DIVU, ALU_REMU};
    endfunction

endpackage

// File: rtl/friscv_muldiv_iter.sv
// -----------------------------------------------------------------------------
// friscv_muldiv_iter
// Iterative multiply (shift-add, low half) and unsigned divide/remainder
// (restoring shift-subtract). One iteration per cycle, WIDTH iterations.
//   clk, rst_n : clock, asynchronous active-low reset
//   abort      : drop the in-flight op
//   start      : load operands and begin (ignored unless a new op is issued)
//   op_sel     : ALU_MUL, ALU_DIVU or ALU_REMU
//   op_a, op_b : multiplicand/dividend, multiplier/divisor
//   done       : single-cycle pulse during the last iteration
//   result     : value produced by the last iteration, valid while done is high
// -----------------------------------------------------------------------------
module friscv_muldiv_iter
    import friscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  alu_op_t          op_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // acc : product accumulator (MUL) or partial remainder (DIVU/REMU)
    // sreg: shifting multiplicand (MUL) or dividend-in / quotient-out (DIV)
    // breg: shifting multiplier (MUL) or fixed divisor (DIV)
    logic [WIDTH-1:0] acc, sreg, breg;
    logic [WIDTH-1:0] acc_nxt, sreg_nxt, breg_nxt;
    logic [CW-1:0]    cnt;
    logic             busy, is_mul, is_rem;
    logic [WIDTH:0]   trial;

    // Remainder shifted left by one dividend bit, minus divisor; the extra
    // MSB is the borrow that decides whether the subtraction is kept.
    assign trial = {acc, sreg[WIDTH-1]} - {1'b0, breg};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        acc_nxt  = acc;
        sreg_nxt = sreg;
        breg_nxt = breg;
        if (is_mul) begin
            if (breg[0]) acc_nxt = acc + sreg;
            sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
            breg_nxt = {1'b0, breg[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_nxt  = trial[WIDTH-1:0];
            sreg_nxt = {sreg[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt  = {acc[WIDTH-2:0], sreg[WIDTH-1]};
            sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
        end
    end

    // With divisor 0 every trial succeeds: quotient becomes all ones and the
    // remainder ends up holding the dividend, which is the required result.
    assign done   = busy && (cnt == LAST);
    assign result = (is_mul || is_rem) ? acc_nxt : sreg_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            sreg   <= '0;
            breg   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            is_mul <= 1'b0;
            is_rem <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            acc    <= '0;
            sreg   <= op_a;
            breg   <= op_b;
            cnt    <= '0;
            busy   <= 1'b1;
            is_mul <= (op_sel == ALU_MUL);
            is_rem <= (op_sel == ALU_REMU);
        end else if (busy) begin
            acc  <= acc_nxt;
            sreg <= sreg_nxt;
            breg <= breg_nxt;
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/friscv_alu_mc.sv
// -----------------------------------------------------------------------------
// friscv_alu_mc
// Execute-stage ALU: nine single-cycle base ops plus iterative MUL/DIVU/REMU,
// with valid/ready handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous abort, returns to IDLE, drops result
//   op_valid / op_ready : request handshake (ready only in IDLE)
//   op_code, op_a, op_b : operation select and operands
//   res_valid/res_ready : result handshake (result held while not accepted)
//   res_data            : result
//   res_zero            : res_data == 0
//   res_dbz             : DIVU/REMU issued with op_b == 0
// -----------------------------------------------------------------------------
module friscv_alu_mc
    import friscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_dbz
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       state;
    logic [WIDTH-1:0] base_res;
    logic [SHW-1:0]   shamt;
    logic             md_start, md_done, pend_dbz;
    logic [WIDTH-1:0] md_result;

    assign shamt    = op_b[SHW-1:0];
    assign op_ready = (state == IDLE);
    assign res_zero = (res_data == '0);
    assign md_start = (state == IDLE) && op_valid && !flush && is_iter_op(op_code);

    always_comb begin
        base_res = '0;
        case (alu_op_t'(op_code))
            ALU_AND: base_res = op_a & op_b;
            ALU_OR:  base_res = op_a | op_b;
            ALU_XOR: base_res = op_a ^ op_b;
            ALU_ADD: base_res = op_a + op_b;
            ALU_SUB: base_res = op_a - op_b;
            ALU_SLT: base_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLL: base_res = op_a << shamt;
            ALU_SAR: base_res = $signed(op_a) >>> shamt;
            ALU_SLR: base_res = op_a >> shamt;
            default: base_res = '0;   // iterative ops and unused codes
        endcase
    end

    friscv_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .abort  (flush),
        .start  (md_start),
        .op_sel (alu_op_t'(op_code)),
        .op_a   (op_a),
        .op_b   (op_b),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_dbz   <= 1'b0;
            pend_dbz  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (is_iter_op(op_code)) begin
                            state    <= BUSY;
                            pend_dbz <= is_div_op(op_code) && (op_b == '0);
                        end else begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res_data  <= base_res;
                            res_dbz   <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= md_result;
                        res_dbz   <= pend_dbz;
                    end
                end
                DONE: begin
                    // A request seen here waits; it is taken from IDLE next.
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_friscv_alu_mc
// Scoreboard bench for friscv_alu_mc (WIDTH = 32). The driver pushes the
// reference result for each accepted op; the monitor pops and compares when
// a new result appears, and checks it stays stable under backpressure.
// -----------------------------------------------------------------------------
module tb_friscv_alu_mc;
    import friscv_pkg::*;

    localparam int W  = 32;
    localparam int SW = $clog2(W);

    logic         clk, rst_n, flush;
    logic         op_valid, op_ready;
    logic [3:0]   op_code;
    logic [W-1:0] op_a, op_b;
    logic         res_valid, res_ready;
    logic [W-1:0] res_data;
    logic         res_zero, res_dbz;

    typedef struct {
        logic [W-1:0] data;
        logic         dbz;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    friscv_alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_dbz   (res_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [SW-1:0] sh;
        sh        = b[SW-1:0];
        e.dbz     = 1'b0;
        e.lat     = 1;
        e.acc_cyc = 0;
        case (op)
            ALU_AND:  e.data = a & b;
            ALU_OR:   e.data = a | b;
            ALU_XOR:  e.data = a ^ b;
            ALU_ADD:  e.data = a + b;
            ALU_SUB:  e.data = a - b;
            ALU_SLT:  e.data = ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_SLL:  e.data = a << sh;
            ALU_SAR:  e.data = $signed(a) >>> sh;
            ALU_SLR:  e.data = a >> sh;
            ALU_MUL:  begin e.data = a * b; e.lat = W + 1; end
            ALU_DIVU: begin e.data = (b == 0) ? '1 : a / b; e.dbz = (b == 0); e.lat = W + 1; end
            ALU_REMU: begin e.data = (b == 0) ? a : a % b;  e.dbz = (b == 0); e.lat = W + 1; end
            default:  e.data = '0;
        endcase
        return e;
    endfunction

    // Monitor: one pop per result; stability checks while it is held.
    always @(negedge clk) begin : monitor
        static logic         seen = 1'b0;
        static logic         have = 1'b0;
        static logic [W-1:0] held = '0;
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (res_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    have = 1'b0;
                    check("unexpected_result", 1, 0);
                end else begin
                    e    = sb.pop_front();
                    have = 1'b1;
                    held = e.data;
                    check("res_data", res_data, e.data);
                    check("res_zero", res_zero, e.data == 0);
                    check("res_dbz", res_dbz, e.dbz);
                    check("latency", cyc - e.acc_cyc, e.lat);
                end
            end else if (have) begin
                check("hold_data", res_data, held);
                check("hold_zero", res_zero, held == 0);
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        op_code  = op;
        op_a     = a;
        op_b     = b;
    endtask

    // Call at a negedge with the request driven; returns just after the
    // accepting edge.
    task automatic accept(input bit push, input bit drop);
        int   n = 0;
        exp_t e;
        while (!op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        e         = model(op_code, op_a, op_b);
        e.acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (push) sb.push_back(e);
        if (drop) begin
            op_valid = 1'b0;
            op_code  = 4'($urandom);
            op_a     = $urandom;
            op_b     = $urandom;
        end
    endtask

    task automatic finish_result(input int hold);
        int n      = 0;
        int rdy_hi = 0;
        @(negedge clk);
        while (!res_valid && n < 100) begin
            if (op_ready) rdy_hi++;
            n++;
            @(negedge clk);
        end
        if (!res_valid) begin
            check("result_timeout", 0, 1);
            return;
        end
        repeat (hold) begin
            if (op_ready) rdy_hi++;
            @(negedge clk);
        end
        if (op_ready) rdy_hi++;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("ready_low", rdy_hi, 0);
        @(negedge clk);
        check("idle_after_release", {res_valid, op_ready}, 2'b01);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        @(negedge clk);
        drive_op(op, a, b);
        accept(1'b1, 1'b1);
        finish_result(hold);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        op_code   = '0;
        op_a      = '0;
        op_b      = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_zero", res_zero, 1);
        check("rst_res_dbz", res_dbz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", op_ready, 1);

        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 0);
        issue(ALU_SAR, 32'h8000_0000, 32'h24, 0);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 0);
        issue(ALU_MUL, 32'hFFFF_FFFF, 32'h3, 0);
        issue(ALU_DIVU, 32'd100, 32'd7, 0);
        issue(ALU_REMU, 32'd100, 32'd7, 0);
        issue(ALU_DIVU, 32'd5, 32'd0, 0);
        issue(ALU_REMU, 32'd5, 32'd0, 1);

        // Backpressure, with a new request held during DONE.
        @(negedge clk);
        drive_op(ALU_SUB, 32'd3, 32'd3);
        accept(1'b1, 1'b0);
        drive_op(ALU_ADD, 32'h1234, 32'h4321);
        finish_result(10);
        accept(1'b1, 1'b1);
        finish_result(0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]   op;
            logic [W-1:0] b;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            issue(op, $urandom, b, $urandom_range(0, 3));
        end

        // Flush ten cycles into a DIVU.
        @(negedge clk);
        drive_op(ALU_DIVU, 32'd1000, 32'd3);
        accept(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", {res_valid, op_ready}, 2'b01);

        // A request presented with flush high is ignored.
        @(negedge clk);
        drive_op(ALU_ADD, 32'd1, 32'd2);
        flush = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        check("flush_reject", op_ready, 1);
        repeat (40) @(negedge clk);
        check("no_result_after_flush", res_valid, 0);

        // Asynchronous reset in the middle of a MUL.
        issue(ALU_DIVU, 32'd5, 32'd0, 0);
        @(negedge clk);
        drive_op(ALU_MUL, 32'h1234_5678, 32'h9);
        accept(1'b0, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_res_valid", res_valid, 0);
        check("async_res_data", res_data, 0);
        check("async_res_zero", res_zero, 1);
        check("async_res_dbz", res_dbz, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", op_ready, 1);
        issue(ALU_ADD, 32'd1, 32'd1, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
